// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and default sizing for the RO-pair PUF comparator.
`default_nettype none

package puf_pkg;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_WINDOW     = 4096;
  localparam int DEF_SETTLE_CYC = 8;

  // Phase timer must reach WINDOW-1 for WINDOW up to 2^20.
  localparam int TIMER_W = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COUNT   = 2'd2,
    COMPARE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: 2-flop synchronizer, rising-edge detect and gated edge counter for one RO.
// Build option RO_CNT_SAT_EN: counter saturates at all-ones and flags it on sat.
`default_nettype none

module ro_edge_counter
  import puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic sync1, sync2, prev;
  logic rise;

  assign rise = sync2 & ~prev;

`ifdef RO_CNT_SAT_EN
  assign sat = &cnt;
`else
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= ro;
      sync2 <= sync1;
      prev  <= sync2;
      if (clr) begin
        cnt <= '0;
      end else if (cnt_en && rise) begin
`ifdef RO_CNT_SAT_EN
        if (!sat) cnt <= cnt + 1'b1;
`else
        cnt <= cnt + 1'b1;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ro_pair_comparator.sv
// ro_pair_comparator: counts edges of two ring oscillators over a fixed window and emits a response bit.
// Build option RO_CNT_SAT_EN: saturating counters; a saturated pair forces RESP=TIE=0.
`default_nettype none

module ro_pair_comparator
  import puf_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             en,
  output logic             busy,
  output logic             valid,
  output logic             resp,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW - 1);

  state_t             state, state_nx;
  logic [TIMER_W-1:0] timer, timer_nx;
  logic               en_nx;
  logic               clr, counting;
  logic [CNT_W-1:0]   raw_a, raw_b;
  logic               sat_a, sat_b, sat_any;

  assign clr      = (state == IDLE) && start;
  assign counting = (state == COUNT);
  assign sat_any  = sat_a | sat_b;

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .ro(ro_a), .clr(clr), .cnt_en(counting), .cnt(raw_a), .sat(sat_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .ro(ro_b), .clr(clr), .cnt_en(counting), .cnt(raw_b), .sat(sat_b)
  );

  // SETTLE spans one clear cycle (EN still low) plus SETTLE_CYC cycles with EN high.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SETTLE;
          timer_nx = '0;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          state_nx = COUNT;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      COUNT: begin
        if (timer == WINDOW_LAST) begin
          state_nx = COMPARE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      COMPARE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    en_nx = (state == SETTLE) || ((state == COUNT) && (state_nx == COUNT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      resp  <= 1'b0;
      tie   <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      en    <= en_nx;
      busy  <= (state_nx != IDLE);
      valid <= (state == COMPARE);
      if (state == COMPARE) begin
        cnt_a <= raw_a;
        cnt_b <= raw_b;
        tie   <= (raw_a == raw_b) && !sat_any;
        resp  <= (raw_a > raw_b) && !sat_any;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ro_pair_comparator.md
RO_PAIR_COMPARATOR -- requirements
Module: ro_pair_comparator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, edge-counter width in bits.
REQ-002 SHALL have parameter WINDOW, default 4096, COUNT-phase length in CLK cycles (1..2^20).
REQ-003 SHALL have parameter SETTLE_CYC, default 8, cycles EN is high before counting starts (1..255).
REQ-004 SHALL have port CLK, input, 1, sole clock.
REQ-005 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port START, input, 1, measurement request, sampled on CLK rising edge.
REQ-007 SHALL have port RO_A, input, 1, oscillator output of slice chain A, asynchronous to CLK.
REQ-008 SHALL have port RO_B, input, 1, oscillator output of slice chain B, asynchronous to CLK.
REQ-009 SHALL have port EN, output, 1, oscillation enable driven to both slice chains.
REQ-010 SHALL have port BUSY, output, 1, high whenever state is not IDLE.
REQ-011 SHALL have port VALID, output, 1, one-cycle result strobe.
REQ-012 SHALL have port RESP, output, 1, response bit: 1 iff CNT_A > CNT_B.
REQ-013 SHALL have port TIE, output, 1, high iff CNT_A == CNT_B.
REQ-014 SHALL have ports CNT_A and CNT_B, output, CNT_W each, final edge counts.

Function
REQ-015 SHALL pass RO_A and RO_B each through a 2-flop synchronizer, then a rising-edge detector (third flop).
REQ-016 SHALL use FSM states IDLE, SETTLE, COUNT, COMPARE; all outputs registered.
REQ-017 IDLE: START=1 SHALL go to SETTLE, clear both counters, assert EN next cycle; START=0 stays.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles with EN=1 and counters held at 0, then go to COUNT.
REQ-019 COUNT SHALL last exactly WINDOW cycles; each detected edge SHALL increment its counter by 1; simultaneous A and B edges SHALL increment both.
REQ-020 On leaving COUNT, EN SHALL deassert in the same cycle the FSM enters COMPARE; edges detected in COMPARE SHALL be ignored.
REQ-021 COMPARE SHALL last 1 cycle and load RESP, TIE, CNT_A, CNT_B; VALID SHALL be 1 in the following cycle only (FSM back in IDLE).
REQ-022 VALID SHALL rise SETTLE_CYC+WINDOW+2 cycles after the edge that sampled START.
REQ-023 RESP, TIE, CNT_A, CNT_B SHALL hold until the next COMPARE; TIE=1 forces RESP=0.
REQ-024 START while BUSY=1 SHALL be ignored; START in the VALID cycle SHALL start a new measurement.
REQ-025 Without saturation, counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-026 RST_N low SHALL immediately force state IDLE, EN=0, BUSY=0, VALID=0, RESP=0, TIE=0, CNT_A=CNT_B=0, synchronizer flops 0.
REQ-027 Reset mid-measurement SHALL abort with no VALID; first START after release starts a clean measurement.

Configuration
REQ-028 Macro RO_CNT_SAT_EN defined: counters SHALL saturate at 2^CNT_W-1, and RESP/TIE SHALL be forced 0 when either count saturated.
REQ-029 Macro RO_CNT_SAT_EN undefined: counters SHALL wrap per REQ-025; no saturation logic SHALL be synthesized.

Structure
REQ-030 Package puf_pkg SHALL hold the FSM state enum and default constants for CNT_W, WINDOW, SETTLE_CYC.
REQ-031 Sub-module ro_edge_counter (synchronizer, edge detect, counter, clear/enable) SHALL be instantiated twice.

Verification
REQ-032 WINDOW=60, SETTLE_CYC=4; RO_A period 6 CLK, RO_B period 10 CLK -> CNT_A in 9..10, CNT_B in 5..6, RESP=1, TIE=0, VALID at cycle 66.
REQ-033 Same config; RO_A and RO_B identical, period 8 CLK -> CNT_A == CNT_B, TIE=1, RESP=0.
REQ-034 START pulsed again at cycles 10 and 30 during busy -> ignored; exactly one VALID.
REQ-035 RST_N low at cycle 20 of COUNT -> EN=0 and counts 0 immediately; no VALID; next START gives a correct result.
REQ-036 CNT_W=4, WINDOW=64, RO_A period 2 CLK -> with RO_CNT_SAT_EN, CNT_A=15 and RESP=0; without it, CNT_A wraps (32 edges -> 0).
REQ-037 RO inputs static -> CNT_A=CNT_B=0, TIE=1, VALID once.
